// File: rtl/conv_issue_ctrl_if.sv
// Handshake and operand-address bundle between the issue controller and its surroundings.
// The controller takes the master side; buffers, pipeline and start logic take the slave side.
interface conv_issue_ctrl_if #(
  parameter int IA_W = 3,
  parameter int FA_W = 3
);
  logic            start;
  logic            ifmap_valid;
  logic            psum_full;
  logic [IA_W-1:0] ifmap_addr;
  logic [FA_W-1:0] filt_addr;
  logic            issue;
  logic            clear;
  logic            co_filter;
  logic            stall;
  logic            busy;
  logic            done;

  modport master (
    input  start, ifmap_valid, psum_full,
    output ifmap_addr, filt_addr, issue, clear, co_filter, stall, busy, done
  );

  modport slave (
    output start, ifmap_valid, psum_full,
    input  ifmap_addr, filt_addr, issue, clear, co_filter, stall, busy, done
  );
endinterface

// File: rtl/conv_issue_ctrl.sv
// Issue sequencer for the two-stage filter pipeline: walks filter/position/tap counters,
// issues one MAC operand pair per unstalled cycle and produces clear/co_filter/done sideband.
module conv_issue_ctrl #(
  parameter int FILT_LEN   = 4,
  parameter int NUM_FILT   = 2,
  parameter int IFMAP_LEN  = 8,
  parameter int STRIDE     = 1,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  conv_issue_ctrl_if.master bus
);
  localparam int NPOS   = (IFMAP_LEN - FILT_LEN) / STRIDE + 1;
  localparam int IA_W   = $clog2(IFMAP_LEN);
  localparam int FA_W   = $clog2(NUM_FILT * FILT_LEN);
  localparam int TAP_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int FILT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int DR_W   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  localparam logic [TAP_W-1:0]  TAP_LAST   = TAP_W'(FILT_LEN - 1);
  localparam logic [IA_W-1:0]   POS_LAST   = IA_W'((NPOS - 1) * STRIDE);
  localparam logic [IA_W-1:0]   POS_STEP   = IA_W'(STRIDE);
  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(NUM_FILT - 1);
  localparam logic [DR_W-1:0]   DRAIN_LAST = DR_W'(PIPE_DEPTH - 1);
  localparam logic [FA_W-1:0]   FA_MUL     = FA_W'(FILT_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [TAP_W-1:0]  r_tap, w_tap_next;
  logic [IA_W-1:0]   r_pos, w_pos_next;
  logic [FILT_W-1:0] r_filt, w_filt_next;
  logic [DR_W-1:0]   r_drain, w_drain_next;

  logic w_stall, w_issue, w_clear, w_co, w_busy, w_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tap   <= '0;
      r_pos   <= '0;
      r_filt  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_tap   <= w_tap_next;
      r_pos   <= w_pos_next;
      r_filt  <= w_filt_next;
      r_drain <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tap_next   = r_tap;
    w_pos_next   = r_pos;
    w_filt_next  = r_filt;
    w_drain_next = r_drain;
    w_stall      = 1'b0;
    w_issue      = 1'b0;
    w_clear      = 1'b0;
    w_co         = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_stall = !bus.ifmap_valid || bus.psum_full;
        w_issue = !w_stall;
        w_clear = w_issue && (r_tap == '0);
        w_co    = w_issue && (r_tap == TAP_LAST);
        // Counters nest tap -> position -> filter; every wrap leaves them at 0 for the next run.
        if (w_issue) begin
          if (r_tap == TAP_LAST) begin
            w_tap_next = '0;
            if (r_pos == POS_LAST) begin
              w_pos_next = '0;
              if (r_filt == FILT_LAST) begin
                w_filt_next  = '0;
                w_drain_next = '0;
                w_state_next = S_DRAIN;
              end else begin
                w_filt_next = r_filt + FILT_W'(1);
              end
            end else begin
              w_pos_next = r_pos + POS_STEP;
            end
          end else begin
            w_tap_next = r_tap + TAP_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) w_state_next = S_DONE;
        else                       w_drain_next = r_drain + DR_W'(1);
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.ifmap_addr = r_pos + IA_W'(r_tap);
  assign bus.filt_addr  = FA_W'(r_filt) * FA_MUL + FA_W'(r_tap);
  assign bus.issue      = w_issue;
  assign bus.clear      = w_clear;
  assign bus.co_filter  = w_co;
  assign bus.stall      = w_stall;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
endmodule

// File: tb/tb_conv_issue_ctrl.sv
// Bench for conv_issue_ctrl: two instances (STRIDE 1 and 2), per-cycle trace logging and a
// list-based reference model of the issue sequence, drain and done timing.
module tb_conv_issue_ctrl;
  localparam int FILT_LEN   = 4;
  localparam int NUM_FILT   = 2;
  localparam int IFMAP_LEN  = 8;
  localparam int PIPE_DEPTH = 3;
  localparam int MAXC       = 128;

  typedef struct packed {
    logic       issue;
    logic       clear;
    logic       co;
    logic       stall;
    logic       busy;
    logic       done;
    logic [2:0] ia;
    logic [2:0] fa;
  } obs_t;

  logic clk = 1'b0;
  logic rst, start, valid, full, sel;
  int   total = 0;
  int   bad   = 0;

  logic        st_start [MAXC];
  logic        st_valid [MAXC];
  logic        st_full  [MAXC];
  logic        st_rst   [MAXC];
  obs_t        obs_log  [MAXC];
  obs_t        exp_log  [MAXC];
  logic [11:0] msk_log  [MAXC];

  always #5 clk = ~clk;

  conv_issue_ctrl_if #(.IA_W(3), .FA_W(3)) bus_a ();
  conv_issue_ctrl_if #(.IA_W(3), .FA_W(3)) bus_b ();

  conv_issue_ctrl #(.FILT_LEN(FILT_LEN), .NUM_FILT(NUM_FILT), .IFMAP_LEN(IFMAP_LEN),
                    .STRIDE(1), .PIPE_DEPTH(PIPE_DEPTH))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  conv_issue_ctrl #(.FILT_LEN(FILT_LEN), .NUM_FILT(NUM_FILT), .IFMAP_LEN(IFMAP_LEN),
                    .STRIDE(2), .PIPE_DEPTH(PIPE_DEPTH))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.start       = start & ~sel;
  assign bus_b.start       = start & sel;
  assign bus_a.ifmap_valid = valid;
  assign bus_b.ifmap_valid = valid;
  assign bus_a.psum_full   = full;
  assign bus_b.psum_full   = full;

  obs_t obs_a, obs_b;
  assign obs_a = {bus_a.issue, bus_a.clear, bus_a.co_filter, bus_a.stall, bus_a.busy,
                  bus_a.done, bus_a.ifmap_addr, bus_a.filt_addr};
  assign obs_b = {bus_b.issue, bus_b.clear, bus_b.co_filter, bus_b.stall, bus_b.busy,
                  bus_b.done, bus_b.ifmap_addr, bus_b.filt_addr};

  task automatic stim_clear();
    for (int c = 0; c < MAXC; c++) begin
      st_start[c] = 1'b0;
      st_valid[c] = 1'b1;
      st_full[c]  = 1'b0;
      st_rst[c]   = 1'b1;
    end
    st_start[0] = 1'b1;
  endtask

  // Entered just after a rising edge; log index c is the cycle following edge c-1.
  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      rst   = st_rst[c];
      start = st_start[c];
      valid = st_valid[c];
      full  = st_full[c];
      @(negedge clk);
      obs_log[c] = sel ? obs_b : obs_a;
      @(posedge clk);
      #1;
    end
    rst = 1'b1; start = 1'b0; valid = 1'b1; full = 1'b0;
  endtask

  // Reference: the run is a flat list of operand pairs consumed one per unstalled cycle,
  // followed by PIPE_DEPTH busy cycles, one done cycle, then idle.
  task automatic build_expected(input int n);
    int   stride = sel ? 2 : 1;
    int   npos   = (IFMAP_LEN - FILT_LEN) / stride + 1;
    int   phase  = 0;
    int   idx    = 0;
    int   dcnt   = 0;
    logic stl;
    obs_t e;
    obs_t ops[$];
    ops = {};
    for (int f = 0; f < NUM_FILT; f++)
      for (int p = 0; p < npos; p++)
        for (int t = 0; t < FILT_LEN; t++) begin
          e       = '0;
          e.issue = 1'b1;
          e.busy  = 1'b1;
          e.clear = (t == 0);
          e.co    = (t == FILT_LEN - 1);
          e.ia    = 3'(p * stride + t);
          e.fa    = 3'(f * FILT_LEN + t);
          ops.push_back(e);
        end
    for (int c = 0; c < n; c++) begin
      stl        = !st_valid[c] || st_full[c];
      e          = '0;
      msk_log[c] = 12'hFFF;
      if (phase == 1) begin
        e = ops[idx];
        if (stl) begin
          e.issue = 1'b0; e.clear = 1'b0; e.co = 1'b0; e.stall = 1'b1;
        end
      end else if (phase == 2) begin
        e.busy = 1'b1; msk_log[c] = 12'hFC0;
      end else if (phase == 3) begin
        e.busy = 1'b1; e.done = 1'b1; msk_log[c] = 12'hFC0;
      end
      exp_log[c] = e;
      if (!st_rst[c]) begin
        phase = 0; idx = 0;
      end else if (phase == 0) begin
        if (st_start[c]) begin phase = 1; idx = 0; end
      end else if (phase == 1) begin
        if (!stl) begin
          idx++;
          if (idx == ops.size()) begin phase = 2; dcnt = 0; end
        end
      end else if (phase == 2) begin
        dcnt++;
        if (dcnt == PIPE_DEPTH) phase = 3;
      end else begin
        phase = 0;
      end
    end
  endtask

  task automatic test_reset();
    stim_clear();
    for (int c = 0; c < 4; c++) st_rst[c] = 1'b0;
    capture(4);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (obs_log[c] !== obs_t'(0)) begin
        bad++; $display("FAIL reset_state cyc=%0d got=%h want=000", c, obs_log[c]);
      end
    end
    $display("test_reset: outputs held low for 4 reset cycles");
  endtask

  task automatic test_nominal();
    int n_iss = 0, done_at = -1;
    stim_clear(); sel = 1'b0;
    capture(47); build_expected(47);
    for (int c = 0; c < 47; c++) begin
      total++;
      if ((obs_log[c] & msk_log[c]) !== (exp_log[c] & msk_log[c])) begin
        bad++; $display("FAIL nom_trace cyc=%0d got=%h want=%h", c, obs_log[c] & msk_log[c], exp_log[c] & msk_log[c]);
      end
      n_iss += int'(obs_log[c].issue);
      if (obs_log[c].done === 1'b1 && done_at < 0) done_at = c;
    end
    total++;
    if (obs_log[1].ia !== 3'd0 || obs_log[1].fa !== 3'd0 || obs_log[1].clear !== 1'b1) begin
      bad++; $display("FAIL nom_cyc1 ia=%0d fa=%0d clear=%b want 0 0 1", obs_log[1].ia, obs_log[1].fa, obs_log[1].clear);
    end
    total++;
    if (obs_log[4].ia !== 3'd3 || obs_log[4].co !== 1'b1) begin
      bad++; $display("FAIL nom_cyc4 ia=%0d co=%b want 3 1", obs_log[4].ia, obs_log[4].co);
    end
    total++;
    if (obs_log[5].ia !== 3'd1 || obs_log[5].clear !== 1'b1) begin
      bad++; $display("FAIL nom_cyc5 ia=%0d clear=%b want 1 1", obs_log[5].ia, obs_log[5].clear);
    end
    total++;
    if (obs_log[21].fa !== 3'd4 || obs_log[21].ia !== 3'd0) begin
      bad++; $display("FAIL nom_cyc21 fa=%0d ia=%0d want 4 0", obs_log[21].fa, obs_log[21].ia);
    end
    total++;
    if (n_iss != 40 || done_at != 44 || obs_log[45].busy !== 1'b0) begin
      bad++; $display("FAIL nom_totals issues=%0d done_at=%0d busy45=%b want 40 44 0", n_iss, done_at, obs_log[45].busy);
    end
    $display("test_nominal: issues=%0d done_at=%0d", n_iss, done_at);
  endtask

  task automatic test_stall_window();
    int n_iss = 0, n_clr = 0, n_co = 0, done_at = -1;
    stim_clear(); sel = 1'b0;
    st_valid[6] = 1'b0; st_valid[7] = 1'b0;
    capture(50); build_expected(50);
    for (int c = 0; c < 50; c++) begin
      total++;
      if ((obs_log[c] & msk_log[c]) !== (exp_log[c] & msk_log[c])) begin
        bad++; $display("FAIL stall_trace cyc=%0d got=%h want=%h", c, obs_log[c] & msk_log[c], exp_log[c] & msk_log[c]);
      end
      n_iss += int'(obs_log[c].issue);
      n_clr += int'(obs_log[c].clear);
      n_co  += int'(obs_log[c].co);
      if (obs_log[c].done === 1'b1 && done_at < 0) done_at = c;
    end
    for (int c = 6; c < 8; c++) begin
      total++;
      if (obs_log[c].stall !== 1'b1 || obs_log[c].issue !== 1'b0 || obs_log[c].ia !== 3'd2 || obs_log[c].fa !== 3'd1) begin
        bad++; $display("FAIL stall_hold cyc=%0d stall=%b issue=%b ia=%0d fa=%0d want 1 0 2 1", c, obs_log[c].stall, obs_log[c].issue, obs_log[c].ia, obs_log[c].fa);
      end
    end
    total++;
    if (n_iss != 40 || n_clr != 10 || n_co != 10 || done_at != 46) begin
      bad++; $display("FAIL stall_totals issues=%0d clears=%0d cos=%0d done_at=%0d want 40 10 10 46", n_iss, n_clr, n_co, done_at);
    end
    $display("test_stall_window: issues=%0d done_at=%0d", n_iss, done_at);
  endtask

  task automatic test_psum_co();
    int done_at = -1;
    stim_clear(); sel = 1'b0;
    for (int c = 4; c < 9; c++) st_full[c] = 1'b1;
    capture(52); build_expected(52);
    for (int c = 0; c < 52; c++) begin
      total++;
      if ((obs_log[c] & msk_log[c]) !== (exp_log[c] & msk_log[c])) begin
        bad++; $display("FAIL psum_trace cyc=%0d got=%h want=%h", c, obs_log[c] & msk_log[c], exp_log[c] & msk_log[c]);
      end
      if (obs_log[c].done === 1'b1 && done_at < 0) done_at = c;
    end
    for (int c = 4; c < 9; c++) begin
      total++;
      if (obs_log[c].co !== 1'b0 || obs_log[c].stall !== 1'b1 || obs_log[c].ia !== 3'd3) begin
        bad++; $display("FAIL psum_hold cyc=%0d co=%b stall=%b ia=%0d want 0 1 3", c, obs_log[c].co, obs_log[c].stall, obs_log[c].ia);
      end
    end
    total++;
    if (obs_log[9].co !== 1'b1 || obs_log[9].ia !== 3'd3 || obs_log[9].fa !== 3'd3 || done_at != 49) begin
      bad++; $display("FAIL psum_release co=%b ia=%0d fa=%0d done_at=%0d want 1 3 3 49", obs_log[9].co, obs_log[9].ia, obs_log[9].fa, done_at);
    end
    $display("test_psum_co: done_at=%0d", done_at);
  endtask

  task automatic test_random();
    int n_iss = 0, n_done = 0;
    stim_clear(); sel = 1'b0;
    for (int c = 1; c < 70; c++) begin
      st_valid[c] = ($urandom_range(0, 99) >= 20);
      st_full[c]  = ($urandom_range(0, 99) < 15);
    end
    capture(120); build_expected(120);
    for (int c = 0; c < 120; c++) begin
      total++;
      if ((obs_log[c] & msk_log[c]) !== (exp_log[c] & msk_log[c])) begin
        bad++; $display("FAIL rand_trace cyc=%0d got=%h want=%h", c, obs_log[c] & msk_log[c], exp_log[c] & msk_log[c]);
      end
      n_iss  += int'(obs_log[c].issue);
      n_done += int'(obs_log[c].done);
    end
    total++;
    if (n_iss != 40 || n_done != 1) begin
      bad++; $display("FAIL rand_totals issues=%0d dones=%0d want 40 1", n_iss, n_done);
    end
    $display("test_random: issues=%0d dones=%0d", n_iss, n_done);
  endtask

  task automatic test_mid_reset();
    int early_done = 0, done_at = -1;
    stim_clear(); sel = 1'b0;
    st_rst[15] = 1'b0; st_start[20] = 1'b1;
    capture(70); build_expected(70);
    for (int c = 0; c < 70; c++) begin
      total++;
      if ((obs_log[c] & msk_log[c]) !== (exp_log[c] & msk_log[c])) begin
        bad++; $display("FAIL rstmid_trace cyc=%0d got=%h want=%h", c, obs_log[c] & msk_log[c], exp_log[c] & msk_log[c]);
      end
      if (c < 60) early_done += int'(obs_log[c].done);
      if (obs_log[c].done === 1'b1 && done_at < 0) done_at = c;
    end
    total++;
    if (obs_log[16] !== obs_t'(0) || early_done != 0) begin
      bad++; $display("FAIL rstmid_abort cyc16=%h early_dones=%0d want 000 0", obs_log[16], early_done);
    end
    total++;
    if (obs_log[21].issue !== 1'b1 || obs_log[21].ia !== 3'd0 || obs_log[21].fa !== 3'd0 || done_at != 64) begin
      bad++; $display("FAIL rstmid_restart issue=%b ia=%0d fa=%0d done_at=%0d want 1 0 0 64", obs_log[21].issue, obs_log[21].ia, obs_log[21].fa, done_at);
    end
    $display("test_mid_reset: restart done_at=%0d", done_at);
  endtask

  task automatic test_stride2();
    int n_iss = 0, done_at = -1, max_ia = 0;
    stim_clear(); sel = 1'b1;
    capture(30); build_expected(30);
    for (int c = 0; c < 30; c++) begin
      total++;
      if ((obs_log[c] & msk_log[c]) !== (exp_log[c] & msk_log[c])) begin
        bad++; $display("FAIL s2_trace cyc=%0d got=%h want=%h", c, obs_log[c] & msk_log[c], exp_log[c] & msk_log[c]);
      end
      n_iss += int'(obs_log[c].issue);
      if (obs_log[c].issue === 1'b1 && int'(obs_log[c].ia) > max_ia) max_ia = int'(obs_log[c].ia);
      if (obs_log[c].done === 1'b1 && done_at < 0) done_at = c;
    end
    total++;
    if (obs_log[1].ia !== 3'd0 || obs_log[5].ia !== 3'd2 || obs_log[9].ia !== 3'd4 || obs_log[9].clear !== 1'b1) begin
      bad++; $display("FAIL s2_bases ia1=%0d ia5=%0d ia9=%0d clr9=%b want 0 2 4 1", obs_log[1].ia, obs_log[5].ia, obs_log[9].ia, obs_log[9].clear);
    end
    total++;
    if (n_iss != 24 || done_at != 28 || max_ia != 7) begin
      bad++; $display("FAIL s2_totals issues=%0d done_at=%0d max_ia=%0d want 24 28 7", n_iss, done_at, max_ia);
    end
    $display("test_stride2: issues=%0d done_at=%0d", n_iss, done_at);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d0 = -1, d1 = -1;
    stim_clear(); sel = 1'b0;
    for (int c = 0; c < 100; c++) st_start[c] = 1'b1;
    capture(100); build_expected(100);
    for (int c = 0; c < 100; c++) begin
      total++;
      if ((obs_log[c] & msk_log[c]) !== (exp_log[c] & msk_log[c])) begin
        bad++; $display("FAIL b2b_trace cyc=%0d got=%h want=%h", c, obs_log[c] & msk_log[c], exp_log[c] & msk_log[c]);
      end
      if (obs_log[c].done === 1'b1) begin
        if (d0 < 0) d0 = c;
        else if (d1 < 0) d1 = c;
      end
    end
    total++;
    if (d0 != 44 || d1 != 89 || obs_log[45].busy !== 1'b0 || obs_log[46].issue !== 1'b1 || obs_log[46].clear !== 1'b1) begin
      bad++; $display("FAIL b2b_timing done0=%0d done1=%0d busy45=%b issue46=%b clr46=%b want 44 89 0 1 1", d0, d1, obs_log[45].busy, obs_log[46].issue, obs_log[46].clear);
    end
    $display("test_back_to_back: dones at %0d and %0d", d0, d1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; valid = 1'b1; full = 1'b0; sel = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_stall_window();
    test_psum_co();
    test_random();
    test_mid_reset();
    test_stride2();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_issue_ctrl.md
Name: conv_issue_ctrl

Overview:
- Sequencer that drives the two-stage filter pipeline.
- Walks filter, output-position and tap counters and issues one multiply-accumulate operand pair per cycle into pipeline stage 1.
- Generates the per-window clear, the co_filter tap carry-out, the stall and the done sideband that travel down the pipeline registers.
- Sits between the top-level start/handshake logic and the ifmap/filter buffers plus the pipeline.

Parameters:
- FILT_LEN, 4: taps per filter.
- NUM_FILT, 2: number of filters processed per run.
- IFMAP_LEN, 8: input feature map length in words.
- STRIDE, 1: position step between output windows.
- PIPE_DEPTH, 3: cycles from issue until the last result leaves the pipeline.
- Derived:
  - NPOS = (IFMAP_LEN-FILT_LEN)/STRIDE+1.
  - IA_W = $clog2(IFMAP_LEN).
  - FA_W = $clog2(NUM_FILT*FILT_LEN).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: synchronous active-low reset.
- start, in, 1: begin a run; sampled only in IDLE.
- ifmap_valid, in, 1: ifmap buffer holds data for the current address.
- psum_full, in, 1: downstream psum buffer cannot accept results.
- ifmap_addr, out, IA_W: ifmap read address = pos_base + tap.
- filt_addr, out, FA_W: filter read address = filt*FILT_LEN + tap.
- issue, out, 1: an operand pair is presented this cycle.
- clear, out, 1: first tap of a window; the accumulator restarts.
- co_filter, out, 1: last tap of a window; the accumulator result is final.
- stall, out, 1: the pipeline must hold this cycle.
- busy, out, 1: the controller is not in IDLE.
- done, out, 1: one-cycle pulse when the run has fully drained.

Behaviour:
- Reset (rst==0 at an edge):
  - State goes to IDLE; tap, pos_base and filt counters clear to 0.
  - Outputs issue, clear, co_filter, stall, busy and done are all 0; both addresses are 0.
  - Reset mid-run aborts immediately; no done is produced.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE: when start==1, move to RUN; counters are already 0.
  - RUN:
    - stall = !ifmap_valid || psum_full.
    - issue = !stall.
    - clear = issue && tap==0.
    - co_filter = issue && tap==FILT_LEN-1.
  - Counter advance, only on issue cycles:
    - tap increments.
    - When tap==FILT_LEN-1, tap wraps to 0 and pos_base += STRIDE.
    - When pos_base also reaches (NPOS-1)*STRIDE, pos_base wraps to 0 and filt increments.
    - When filt also reaches NUM_FILT-1 (the final tap), go to DRAIN.
  - Stalled RUN cycles: all counters and addresses hold; issue, clear and co_filter are 0.
  - DRAIN: a drain counter counts PIPE_DEPTH cycles and then moves to DONE. stall is forced 0 and inputs are ignored.
  - DONE: done=1 for exactly one cycle, then return to IDLE. A start asserted in DONE is ignored.
- busy = 1 in RUN, DRAIN and DONE.
- Addresses are combinational from the counters.
  - ifmap_addr never exceeds IFMAP_LEN-1.
  - filt_addr never exceeds NUM_FILT*FILT_LEN-1.
- Latency: start sampled at edge 0 gives the first issue in cycle 1.
- Total issue count per run = NUM_FILT*NPOS*FILT_LEN.
- start held high across the return to IDLE launches a new run on the following edge.
- FILT_LEN==1: clear and co_filter are both 1 on every issue.
- Simultaneous !ifmap_valid and psum_full: a single stall; there is no separate priority.

Test Plan (defaults unless noted, so NPOS=5 and 40 issues per run):
- Reset then start pulse, ifmap_valid=1, psum_full=0:
  - issue=1 for cycles 1..40.
  - Cycle 1: ifmap_addr=0, filt_addr=0, clear=1.
  - Cycle 4: ifmap_addr=3, co_filter=1.
  - Cycle 5: ifmap_addr=1, clear=1.
  - Cycle 21: filt_addr=4, ifmap_addr=0.
  - Cycles 41..43: DRAIN; done=1 in cycle 44; busy=0 in cycle 45.
- Drop ifmap_valid in cycles 6-7:
  - stall=1 and issue=0 in those cycles; addresses held at ifmap_addr=2, filt_addr=1.
  - done moves to cycle 46; still 40 issues, 10 clear pulses and 10 co_filter pulses.
- psum_full=1 for 5 cycles on a co_filter cycle: co_filter is deferred and asserts only on the first cycle after release, with unchanged addresses.
- rst=0 in cycle 15:
  - Next cycle all outputs are 0, busy=0, and done never pulses.
  - A fresh start restarts at ifmap_addr=0, filt_addr=0.
- STRIDE=2, IFMAP_LEN=8, FILT_LEN=4: NPOS=3; window bases 0, 2, 4; max ifmap_addr=7; 24 issues; done in cycle 28.
- start held high continuously: back-to-back runs with a done pulse every 45 cycles and a single IDLE cycle between runs.
